// File: rtl/adpll_pkg.sv
// Shared types and defaults for the ADPLL loop-control blocks.
package adpll_pkg;

  localparam int DEF_ERR_W = 8;
  localparam int GAIN_W    = 4;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [GAIN_W-1:0] kp;
    logic [GAIN_W-1:0] ki;
  } gain_t;

endpackage

// File: rtl/run_length_counter.sv
// Saturating run-length counter: counts consecutive valid hits, zeroes on a
// valid miss, holds on invalid cycles, and clears on request.
module run_length_counter #(
  parameter int CNT_W = 8
) (
  input  logic             gen_clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             hit_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins, then valid hit/miss, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (valid_i) begin
      if (!hit_i)                 count_d = '0;
      else if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge gen_clk_i) begin
    // NOTE: non-blocking assignments in clocked blocks keep all flops updating from pre-edge values.
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/loop_gain_scheduler.sv
// Steps the ADPLL loop filter through ACQUIRE -> TRACK -> LOCKED based on runs
// of small/large phase error, and drives the matching gain shifts.
module loop_gain_scheduler
  import adpll_pkg::*;
#(
  parameter int ERR_W        = DEF_ERR_W,
  parameter int SHIFT_W      = GAIN_W,
  parameter int CNT_W        = 8,
  parameter int LOCK_TOL     = 4,
  parameter int TRACK_TOL    = 2,
  parameter int UNLOCK_TOL   = 16,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int ACQ_KP       = 1,
  parameter int ACQ_KI       = 4,
  parameter int TRK_KP       = 3,
  parameter int TRK_KI       = 7,
  parameter int LCK_KP       = 4,
  parameter int LCK_KI       = 9
) (
  input  logic               gen_clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               error_valid_i,
  input  logic [ERR_W-1:0]   error_i,
  output logic [SHIFT_W-1:0] kp_shift_o,
  output logic [SHIFT_W-1:0] ki_shift_o,
  output logic               gain_update_o,
  output logic               lock_o,
  output logic [1:0]         state_o
);

  localparam logic [ERR_W-1:0] ERR_MIN      = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX      = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0] LOCK_TOL_V   = ERR_W'(LOCK_TOL);
  localparam logic [ERR_W-1:0] TRACK_TOL_V  = ERR_W'(TRACK_TOL);
  localparam logic [ERR_W-1:0] UNLOCK_TOL_V = ERR_W'(UNLOCK_TOL);
  localparam logic [CNT_W-1:0] GOOD_LAST    = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] BAD_LAST     = CNT_W'(UNLOCK_COUNT - 1);

  function automatic gain_t gains_for(input sched_state_t s);
    gain_t g;
    case (s)
      TRACK:   begin g.kp = GAIN_W'(TRK_KP); g.ki = GAIN_W'(TRK_KI); end
      LOCKED:  begin g.kp = GAIN_W'(LCK_KP); g.ki = GAIN_W'(LCK_KI); end
      default: begin g.kp = GAIN_W'(ACQ_KP); g.ki = GAIN_W'(ACQ_KI); end
    endcase
    return g;
  endfunction

  sched_state_t     state_d, state_q;
  gain_t            gain_d, gain_q;
  logic             lock_d, lock_q;
  logic             update_d, update_q;
  logic [ERR_W-1:0] abs_err;
  logic             good_hit, bad_hit, good_fire, bad_fire, cnt_clear;
  logic [CNT_W-1:0] good_cnt, bad_cnt;

  // Saturating magnitude of the error and per-state good/bad classification.
  always_comb begin
    if (!error_i[ERR_W-1])    abs_err = error_i;
    else if (error_i == ERR_MIN) abs_err = ERR_MAX;
    else                      abs_err = -error_i;
    good_hit = (state_q == ACQUIRE) ? (abs_err <= LOCK_TOL_V) : (abs_err <= TRACK_TOL_V);
    bad_hit  = abs_err > UNLOCK_TOL_V;
  end

  run_length_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .valid_i   (error_valid_i),
    .hit_i     (good_hit),
    .clear_i   (cnt_clear),
    .count_o   (good_cnt)
  );

  run_length_counter #(.CNT_W(CNT_W)) u_bad_cnt (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .valid_i   (error_valid_i),
    .hit_i     (bad_hit),
    .clear_i   (cnt_clear),
    .count_o   (bad_cnt)
  );

  // Next state and the registered outputs that follow from it; a bad run beats a good run.
  always_comb begin
    good_fire = error_valid_i && good_hit && (good_cnt >= GOOD_LAST);
    bad_fire  = error_valid_i && bad_hit  && (bad_cnt  >= BAD_LAST);
    state_d   = state_q;
    if (!enable_i) begin
      state_d = ACQUIRE;
    end else begin
      case (state_q)
        ACQUIRE: if (good_fire) state_d = TRACK;
        TRACK: begin
          if (bad_fire)       state_d = ACQUIRE;
          else if (good_fire) state_d = LOCKED;
        end
        LOCKED:  if (bad_fire)  state_d = ACQUIRE;
        default: state_d = ACQUIRE;
      endcase
    end
    update_d  = (state_d != state_q);
    cnt_clear = update_d || !enable_i;
    gain_d    = gains_for(state_d);
    lock_d    = (state_d == LOCKED);
  end

  // FSM state and output registers; reset dominates enable.
  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      state_q  <= ACQUIRE;
      gain_q   <= gains_for(ACQUIRE);
      lock_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      lock_q   <= lock_d;
      update_q <= update_d;
    end
  end

  assign kp_shift_o    = SHIFT_W'(gain_q.kp);
  assign ki_shift_o    = SHIFT_W'(gain_q.ki);
  assign gain_update_o = update_q;
  assign lock_o        = lock_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Directed bench for loop_gain_scheduler: phase progression, unlock, tolerance
// boundaries, sparse samples, and reset/enable abandonment.
module tb_loop_gain_scheduler;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b1;
  logic       error_valid_i = 1'b0;
  logic [7:0] error_i = 8'd0;
  logic [3:0] kp_shift_o, ki_shift_o;
  logic       gain_update_o, lock_o;
  logic [1:0] state_o;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  // Observation word: {state, kp, ki, lock, gain_update}
  localparam logic [11:0] ACQ_IDLE = {2'd0, 4'd1, 4'd4, 1'b0, 1'b0};
  localparam logic [11:0] ACQ_UPD  = {2'd0, 4'd1, 4'd4, 1'b0, 1'b1};
  localparam logic [11:0] TRK_IDLE = {2'd1, 4'd3, 4'd7, 1'b0, 1'b0};
  localparam logic [11:0] TRK_UPD  = {2'd1, 4'd3, 4'd7, 1'b0, 1'b1};
  localparam logic [11:0] LCK_IDLE = {2'd2, 4'd4, 4'd9, 1'b1, 1'b0};
  localparam logic [11:0] LCK_UPD  = {2'd2, 4'd4, 4'd9, 1'b1, 1'b1};

  assign obs = {state_o, kp_shift_o, ki_shift_o, lock_o, gain_update_o};

  always #5 clk = ~clk;

  loop_gain_scheduler dut (
    .gen_clk_i     (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .error_valid_i (error_valid_i),
    .error_i       (error_i),
    .kp_shift_o    (kp_shift_o),
    .ki_shift_o    (ki_shift_o),
    .gain_update_o (gain_update_o),
    .lock_o        (lock_o),
    .state_o       (state_o)
  );

  // One sample cycle; outputs are stable 1 time unit after the edge.
  task automatic step(input logic valid, input logic [7:0] err);
    error_valid_i = valid;
    error_i       = err;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [7:0] err);
    for (int i = 0; i < n; i++) step(1'b1, err);
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    step(1'b1, 8'd3);
    step(1'b1, 8'd3);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL reset_hold: got %h want %h", obs, ACQ_IDLE);
    end
    reset_i = 1'b0;
    step(1'b0, 8'd0);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs, ACQ_IDLE);
    end
  endtask

  task automatic test_acquire_hold;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 8'd10);
      checks++;
      if (obs !== ACQ_IDLE) begin
        errors++; $display("FAIL acq_hold[%0d]: got %h want %h", i, obs, ACQ_IDLE);
      end
    end
  endtask

  task automatic test_track_lock;
    run(15, 8'd3);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL acq_15th: got %h want %h", obs, ACQ_IDLE);
    end
    step(1'b1, 8'd3);
    checks++;
    if (obs !== TRK_UPD) begin
      errors++; $display("FAIL to_track: got %h want %h", obs, TRK_UPD);
    end
    step(1'b1, 8'd1);
    checks++;
    if (obs !== TRK_IDLE) begin
      errors++; $display("FAIL track_pulse_end: got %h want %h", obs, TRK_IDLE);
    end
    run(14, 8'd1);
    checks++;
    if (obs !== TRK_IDLE) begin
      errors++; $display("FAIL track_15th: got %h want %h", obs, TRK_IDLE);
    end
    step(1'b1, 8'd1);
    checks++;
    if (obs !== LCK_UPD) begin
      errors++; $display("FAIL to_locked: got %h want %h", obs, LCK_UPD);
    end
    step(1'b1, 8'd0);
    checks++;
    if (obs !== LCK_IDLE) begin
      errors++; $display("FAIL locked_pulse_end: got %h want %h", obs, LCK_IDLE);
    end
  endtask

  task automatic test_unlock;
    run(3, 8'hEC);                  // -20
    step(1'b1, 8'd0);
    run(3, 8'hEC);
    checks++;
    if (obs !== LCK_IDLE) begin
      errors++; $display("FAIL locked_survives: got %h want %h", obs, LCK_IDLE);
    end
    step(1'b1, 8'hEC);
    checks++;
    if (obs !== ACQ_UPD) begin
      errors++; $display("FAIL unlock: got %h want %h", obs, ACQ_UPD);
    end
  endtask

  task automatic test_boundaries;
    // -4 good, -5 breaks the run in ACQUIRE
    run(15, 8'hFC);
    step(1'b1, 8'hFB);
    run(15, 8'hFC);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL lock_tol_edge: got %h want %h", obs, ACQ_IDLE);
    end
    step(1'b1, 8'hFC);
    checks++;
    if (obs !== TRK_UPD) begin
      errors++; $display("FAIL neg4_good: got %h want %h", obs, TRK_UPD);
    end
    // 17 bad, 16 is not bad
    run(3, 8'd17);
    step(1'b1, 8'd16);
    run(3, 8'd17);
    checks++;
    if (obs !== TRK_IDLE) begin
      errors++; $display("FAIL unlock_tol_edge: got %h want %h", obs, TRK_IDLE);
    end
    step(1'b1, 8'd17);
    checks++;
    if (obs !== ACQ_UPD) begin
      errors++; $display("FAIL track_unlock17: got %h want %h", obs, ACQ_UPD);
    end
    // -128 saturates to 127 and counts bad
    run(16, 8'd3);
    run(3, 8'h80);
    checks++;
    if (obs !== TRK_IDLE) begin
      errors++; $display("FAIL min_err_3: got %h want %h", obs, TRK_IDLE);
    end
    step(1'b1, 8'h80);
    checks++;
    if (obs !== ACQ_UPD) begin
      errors++; $display("FAIL min_err_bad: got %h want %h", obs, ACQ_UPD);
    end
    // Good run near threshold, then a bad run: falls back, never locks
    run(16, 8'd3);
    run(15, 8'd1);
    run(3, 8'd17);
    checks++;
    if (obs !== TRK_IDLE) begin
      errors++; $display("FAIL bad_after_good_3: got %h want %h", obs, TRK_IDLE);
    end
    step(1'b1, 8'd17);
    checks++;
    if (obs !== ACQ_UPD) begin
      errors++; $display("FAIL bad_wins: got %h want %h", obs, ACQ_UPD);
    end
  endtask

  task automatic test_sparse_valid;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) step(1'b0, 8'd100);
      step(1'b1, 8'd3);
      checks++;
      if (i < 15) begin
        if (obs !== ACQ_IDLE) begin
          errors++; $display("FAIL sparse[%0d]: got %h want %h", i, obs, ACQ_IDLE);
        end
      end else if (obs !== TRK_UPD) begin
        errors++; $display("FAIL sparse_to_track: got %h want %h", obs, TRK_UPD);
      end
    end
  endtask

  task automatic test_abandon;
    run(16, 8'd1);
    checks++;
    if (obs !== LCK_UPD) begin
      errors++; $display("FAIL abandon_setup: got %h want %h", obs, LCK_UPD);
    end
    // Reset in LOCKED, even with enable high and a valid sample present
    reset_i = 1'b1;
    step(1'b1, 8'd0);
    reset_i = 1'b0;
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL reset_locked: got %h want %h", obs, ACQ_IDLE);
    end
    // Reset clears a partial good run
    run(10, 8'd3);
    reset_i = 1'b1;
    step(1'b0, 8'd0);
    reset_i = 1'b0;
    run(15, 8'd3);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL reset_clears_cnt: got %h want %h", obs, ACQ_IDLE);
    end
    step(1'b1, 8'd3);
    run(16, 8'd0);
    checks++;
    if (obs !== LCK_UPD) begin
      errors++; $display("FAIL relock: got %h want %h", obs, LCK_UPD);
    end
    // Enable drop in LOCKED pulses once
    enable_i = 1'b0;
    step(1'b0, 8'd0);
    checks++;
    if (obs !== ACQ_UPD) begin
      errors++; $display("FAIL disable_locked: got %h want %h", obs, ACQ_UPD);
    end
    step(1'b1, 8'd0);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL disable_hold: got %h want %h", obs, ACQ_IDLE);
    end
    enable_i = 1'b1;
    // Enable drop in ACQUIRE: no pulse, partial run discarded
    run(10, 8'd3);
    enable_i = 1'b0;
    step(1'b0, 8'd0);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL disable_acq_nopulse: got %h want %h", obs, ACQ_IDLE);
    end
    enable_i = 1'b1;
    run(15, 8'd3);
    checks++;
    if (obs !== ACQ_IDLE) begin
      errors++; $display("FAIL disable_clears_cnt: got %h want %h", obs, ACQ_IDLE);
    end
    step(1'b1, 8'd3);
    checks++;
    if (obs !== TRK_UPD) begin
      errors++; $display("FAIL track_after_enable: got %h want %h", obs, TRK_UPD);
    end
  endtask

  initial begin
    test_reset;
    test_acquire_hold;
    test_track_lock;
    test_unlock;
    test_boundaries;
    test_sparse_valid;
    test_abandon;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
